// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state codes, the
// start/stop request levels and the result-ready levels seen by EX.
package div_seq_pkg;

    // Operand width of the divider; the iteration count equals this width.
    localparam int DIV_DATA_W = 32;

    // Divider sequencing states.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Request level driven by EX on start_i.
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Level of ready_o.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage : div_seq_pkg

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU. Produces one quotient bit per
// clock, result packed as {remainder, quotient} for HI/LO.
//
// Handshake: EX raises start_i (DIV_START) with the operands valid and holds
// it, together with its stall, until ready_o is seen high. ready_o stays high
// and result_o stays stable for as long as start_i remains high; dropping
// start_i (DIV_STOP) returns the unit to FREE on the next edge. A new
// operation can only begin from FREE, so start_i must be low for at least one
// edge between operations. annul_i aborts whatever is in flight and wins over
// both start_i and completion.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output div_state_e          state_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   dvd, dvd_nxt;         // dividend magnitude, quotient bits shift in at lsb
    logic [DATA_W-1:0]   dvs_mag, dvs_mag_nxt;
    logic [DATA_W-1:0]   rem, rem_nxt;         // partial remainder
    logic                neg_quo, neg_quo_nxt;
    logic                neg_rem, neg_rem_nxt;
    logic [2*DATA_W-1:0] result_nxt;
    logic                ready_nxt;

    // Sign-magnitude conversion of the incoming operands.
    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_mag, op2_mag;

    // Single restoring step. The shifted remainder keeps its top bit so the
    // compare is a full DATA_W+1-bit subtract.
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     diff;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                last_step;

    assign op1_neg   = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg   = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_mag   = op1_neg ? (DATA_W'(0) - opdata1_i) : opdata1_i;
    assign op2_mag   = op2_neg ? (DATA_W'(0) - opdata2_i) : opdata2_i;

    assign rem_shift = {rem, dvd[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, dvs_mag};
    assign q_bit     = ~diff[DATA_W];
    assign rem_step  = q_bit ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    assign quo_step  = {dvd[DATA_W-2:0], q_bit};
    assign quo_fix   = neg_quo ? (DATA_W'(0) - quo_step) : quo_step;
    assign rem_fix   = neg_rem ? (DATA_W'(0) - rem_step) : rem_step;
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    assign state_o   = state;

    // Next-state and next-register computation; annul overrides everything.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dvd_nxt     = dvd;
        dvs_mag_nxt = dvs_mag;
        rem_nxt     = rem;
        neg_quo_nxt = neg_quo;
        neg_rem_nxt = neg_rem;
        result_nxt  = result_o;
        ready_nxt   = ready_o;

        if (annul_i) begin
            state_nxt  = DIV_FREE;
            cnt_nxt    = '0;
            result_nxt = '0;
            ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START) begin
                        if (opdata2_i == '0) begin
                            state_nxt = DIV_BY_ZERO;
                        end else begin
                            state_nxt   = DIV_ON;
                            dvd_nxt     = op1_mag;
                            dvs_mag_nxt = op2_mag;
                            neg_quo_nxt = op1_neg ^ op2_neg;
                            neg_rem_nxt = op1_neg;
                            rem_nxt     = '0;
                            cnt_nxt     = '0;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state_nxt  = DIV_END;
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_READY;
                end
                DIV_ON: begin
                    dvd_nxt = quo_step;
                    rem_nxt = rem_step;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (last_step) begin
                        state_nxt  = DIV_END;
                        result_nxt = {rem_fix, quo_fix};
                        ready_nxt  = DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state_nxt  = DIV_FREE;
                        result_nxt = '0;
                        ready_nxt  = DIV_RESULT_NOT_READY;
                    end
                end
                default: begin
                    state_nxt  = DIV_FREE;
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvs_mag  <= '0;
            rem      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dvd      <= dvd_nxt;
            dvs_mag  <= dvs_mag_nxt;
            rem      <= rem_nxt;
            neg_quo  <= neg_quo_nxt;
            neg_rem  <= neg_rem_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by
// zero, annul, END hold, back-to-back operations and asynchronous reset.
module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    div_state_e  state_o;

    int vectors     = 0;
    int miscompares = 0;

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .state_o      (state_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Drive one request at a negedge; the following posedge is edge 1 (capture).
    // Returns the edge count at which ready_o was seen, or max_edges if not.
    // Operands are scrambled right after capture to show they are not re-sampled.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int max_edges, output logic [63:0] res, output int edges);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        res          = '0;
        while (edges < max_edges) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom_range(1, 32'h7fff_ffff);
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) begin
                res = result_o;
                break;
            end
        end
    endtask

    // Release the request and step one edge.
    task automatic drop_start;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reset values while rst is held low.
    task automatic test_reset;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ready_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready got %0b want 0", ready_o);
        end
        vectors++;
        if (result_o !== 64'h0) begin
            miscompares++; $display("FAIL reset_result got %h want 0", result_o);
        end
        vectors++;
        if (state_o !== DIV_FREE) begin
            miscompares++; $display("FAIL reset_state got %0d want %0d", state_o, DIV_FREE);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One complete operation: latency, result, then release back to FREE.
    task automatic test_vector(input string name, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp_res, input int exp_edges);
        logic [63:0] res;
        int          edges;
        do_div(sgn, a, b, 100, res, edges);
        vectors++;
        if (edges !== exp_edges) begin
            miscompares++; $display("FAIL %s latency got %0d want %0d", name, edges, exp_edges);
        end
        vectors++;
        if (res !== exp_res) begin
            miscompares++; $display("FAIL %s result got %h want %h", name, res, exp_res);
        end
        drop_start();
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'h0 || state_o !== DIV_FREE) begin
            miscompares++;
            $display("FAIL %s release got ready=%0b result=%h state=%0d want 0/0/FREE",
                     name, ready_o, result_o, state_o);
        end
    endtask

    task automatic test_unsigned;
        test_vector("divu_7_2",   1'b0, 32'd7,        32'd2,        {32'h1, 32'h3}, 33);
        test_vector("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'h1,        {32'h0, 32'hFFFFFFFF}, 33);
        test_vector("divu_big",   1'b0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'h1}, 33);
        test_vector("divu_small", 1'b0, 32'd5,        32'd9,        {32'h5, 32'h0}, 33);
    endtask

    task automatic test_signed;
        test_vector("div_m7_2",  1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        test_vector("div_7_m2",  1'b1, 32'd7,        32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33);
        test_vector("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'h3}, 33);
        test_vector("div_wrap",  1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    endtask

    task automatic test_by_zero;
        test_vector("div_zero",  1'b1, 32'h12345678, 32'h0, 64'h0, 2);
        test_vector("divu_zero", 1'b0, 32'hFFFFFFFF, 32'h0, 64'h0, 2);
    endtask

    // Result stays held in END while start_i remains high.
    task automatic test_end_hold;
        logic [63:0] res;
        int          edges;
        int          bad;
        do_div(1'b0, 32'd1000, 32'd3, 100, res, edges);
        vectors++;
        if (res !== {32'h1, 32'd333}) begin
            miscompares++; $display("FAIL end_hold result got %h want %h", res, {32'h1, 32'd333});
        end
        bad = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b1 || result_o !== {32'h1, 32'd333} || state_o !== DIV_END) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL end_hold held_cycles_bad got %0d want 0", bad);
        end
        drop_start();
        vectors++;
        if (state_o !== DIV_FREE || ready_o !== 1'b0) begin
            miscompares++; $display("FAIL end_hold release got state=%0d ready=%0b want FREE/0", state_o, ready_o);
        end
    endtask

    // Annul mid-iteration, annul on the completion edge, annul out of BYZERO.
    task automatic test_annul;
        logic [63:0] res;
        int          edges;
        int          seen;
        do_div(1'b0, 32'd100, 32'd7, 10, res, edges);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (state_o !== DIV_FREE || ready_o !== 1'b0 || result_o !== 64'h0) begin
            miscompares++;
            $display("FAIL annul_mid got state=%0d ready=%0b result=%h want FREE/0/0", state_o, ready_o, result_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++; $display("FAIL annul_no_ready got %0d ready cycles want 0", seen);
        end
        test_vector("after_annul", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);

        // Completion would occur on edge 33; annul on that same edge wins.
        do_div(1'b0, 32'd100, 32'd7, 32, res, edges);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (state_o !== DIV_FREE || ready_o !== 1'b0) begin
            miscompares++; $display("FAIL annul_at_done got state=%0d ready=%0b want FREE/0", state_o, ready_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;

        // Annul while in BYZERO.
        do_div(1'b0, 32'd5, 32'd0, 1, res, edges);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (state_o !== DIV_FREE || ready_o !== 1'b0) begin
            miscompares++; $display("FAIL annul_byzero got state=%0d ready=%0b want FREE/0", state_o, ready_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Operations with only the one mandatory FREE edge between them.
    task automatic test_back_to_back;
        test_vector("b2b_a", 1'b0, 32'd50,       32'd6, {32'h2, 32'h8}, 33);
        test_vector("b2b_b", 1'b1, 32'hFFFFFF9C, 32'd6, {32'hFFFFFFFC, 32'hFFFFFFF0}, 33);
    endtask

    // Asynchronous reset mid-ON and in END, then a fresh operation.
    task automatic test_async_reset;
        logic [63:0] res;
        int          edges;
        do_div(1'b0, 32'd77, 32'd5, 15, res, edges);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (state_o !== DIV_FREE || ready_o !== 1'b0 || result_o !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_mid_on got state=%0d ready=%0b result=%h want FREE/0/0", state_o, ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        do_div(1'b0, 32'd77, 32'd5, 100, res, edges);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            miscompares++; $display("FAIL rst_in_end got ready=%0b result=%h want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        test_vector("after_rst", 1'b0, 32'd77, 32'd5, {32'h2, 32'hF}, 33);
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_by_zero();
        test_end_hold();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_div_seq
